// File: rtl/fsm_code_monitor_if.sv
// Bundles the observed state code, the host clear and all monitor status outputs.
// The master side (host/debug) drives code_in and clr; the slave side is the monitor.
interface fsm_code_monitor_if #(
  parameter int CODE_W = 17,
  parameter int CNT_W  = 8
);
  logic [CODE_W-1:0] code_in;
  logic              clr;
  logic [3:0]        step_idx;
  logic              advance;
  logic              fallback;
  logic              illegal_code;
  logic              stall;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  fail_count;
  logic [3:0]        max_step;

  modport master (
    output code_in, clr,
    input  step_idx, advance, fallback, illegal_code, stall, done, err, fail_count, max_step
  );

  modport slave (
    input  code_in, clr,
    output step_idx, advance, fallback, illegal_code, stall, done, err, fail_count, max_step
  );
endinterface

// File: rtl/fsm_code_monitor.sv
// Passive checker for the sequence FSM: decodes its 17-bit state code into steps 1..13
// and flags advances, fallbacks, illegal codes/transitions, stalls and completion.
module fsm_code_monitor #(
  parameter int CODE_W      = 17,
  parameter int CNT_W       = 8,
  parameter int STALL_LIMIT = 1000,
  parameter int STALL_W     = 10
) (
  input  logic               clk,
  input  logic               reset,
  fsm_code_monitor_if.slave  bus
);

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE, M_ERR} mon_state_t;

  localparam logic [STALL_W-1:0] LIMIT_V = STALL_W'(STALL_LIMIT);

  mon_state_t          r_state;
  logic [CODE_W-1:0]   r_code;
  logic [3:0]          r_step_idx;
  logic [3:0]          r_max_step;
  logic [STALL_W-1:0]  r_run;
  logic [CNT_W-1:0]    r_fail_count;
  logic                r_advance;
  logic                r_fallback;
  logic                r_illegal;
  logic                r_stall;
  logic                r_done;
  logic                r_err;

  logic [3:0]          w_idx;
  logic                w_known;
  logic                w_same;
  logic                w_adv;
  logic                w_fall;
  logic                w_bad;
  logic [3:0]          w_step_next;
  logic [STALL_W-1:0]  w_run_next;
  logic                w_stall_next;

  // Index 0 marks a code that is not in the table.
  always_comb begin
    w_idx = 4'd0;
    case (r_code)
      CODE_W'(0):    w_idx = 4'd1;
      CODE_W'(200):  w_idx = 4'd2;
      CODE_W'(700):  w_idx = 4'd3;
      CODE_W'(900):  w_idx = 4'd4;
      CODE_W'(1300): w_idx = 4'd5;
      CODE_W'(1800): w_idx = 4'd6;
      CODE_W'(2300): w_idx = 4'd7;
      CODE_W'(2800): w_idx = 4'd8;
      CODE_W'(3100): w_idx = 4'd9;
      CODE_W'(3400): w_idx = 4'd10;
      CODE_W'(3600): w_idx = 4'd11;
      CODE_W'(3800): w_idx = 4'd12;
      CODE_W'(4100): w_idx = 4'd13;
      default:       w_idx = 4'd0;
    endcase
  end

  always_comb begin
    w_known     = (w_idx != 4'd0);
    w_same      = w_known && (w_idx == r_step_idx);
    w_adv       = w_known && (w_idx == r_step_idx + 4'd1);
    w_fall      = w_known && (w_idx == 4'd1) && (r_step_idx >= 4'd2) && (r_step_idx <= 4'd12);
    w_bad       = w_known && !w_same && !w_adv && !w_fall;
    w_step_next = w_known ? w_idx : r_step_idx;
    if (!w_known) begin
      w_run_next = r_run;
    end else if (w_same) begin
      w_run_next = (r_run == '1) ? r_run : r_run + 1'b1;
    end else begin
      w_run_next = STALL_W'(1);
    end
    w_stall_next = (w_run_next >= LIMIT_V) && (w_step_next >= 4'd2) && (w_step_next <= 4'd12);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= M_IDLE;
      r_code       <= '0;
      r_step_idx   <= 4'd1;
      r_max_step   <= 4'd1;
      r_run        <= '0;
      r_fail_count <= '0;
      r_advance    <= 1'b0;
      r_fallback   <= 1'b0;
      r_illegal    <= 1'b0;
      r_stall      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_code     <= bus.code_in;
      r_step_idx <= w_step_next;
      r_advance  <= 1'b0;
      r_fallback <= 1'b0;
      r_illegal  <= 1'b0;
      if (bus.clr) begin
        // The transition decoded on a clear edge is dropped; only step tracking survives.
        r_state      <= M_IDLE;
        r_run        <= '0;
        r_stall      <= 1'b0;
        r_fail_count <= '0;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
        r_max_step   <= r_step_idx;
      end else begin
        r_run      <= w_run_next;
        r_stall    <= w_stall_next;
        r_advance  <= w_adv;
        r_fallback <= w_fall;
        r_illegal  <= !w_known;
        if (w_fall && (r_fail_count != '1)) r_fail_count <= r_fail_count + 1'b1;
        if (w_idx == 4'd13) r_done <= 1'b1;
        if (w_known && (w_idx > r_max_step)) r_max_step <= w_idx;
        if (!w_known || w_bad) begin
          r_err   <= 1'b1;
          r_state <= M_ERR;
        end else begin
          case (r_state)
            M_IDLE:  if (w_adv) r_state <= M_RUN;
            M_RUN: begin
              if (w_fall) r_state <= M_IDLE;
              else if (w_adv && (w_idx == 4'd13)) r_state <= M_DONE;
            end
            M_DONE:  r_state <= M_DONE;
            default: r_state <= M_ERR;
          endcase
        end
      end
    end
  end

  assign bus.step_idx     = r_step_idx;
  assign bus.advance      = r_advance;
  assign bus.fallback     = r_fallback;
  assign bus.illegal_code = r_illegal;
  assign bus.stall        = r_stall;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.fail_count   = r_fail_count;
  assign bus.max_step     = r_max_step;

endmodule
